// File: rtl/vsfx_wb_pkg.sv
// Shared widths and the result-queue entry layout for the VSFX writeback stage.
package vsfx_wb_pkg;

    localparam int VR_W  = 128;
    localparam int VRA_W = 5;
    localparam int CR_W  = 4;

    typedef struct packed {
        logic [VRA_W-1:0] addr;
        logic [VR_W-1:0]  data;
        logic             sat;
        logic [CR_W-1:0]  cr6;
        logic             rc;
    } wb_entry_t;

    localparam int ENT_W = $bits(wb_entry_t);

endpackage

// File: rtl/vsfx_wb_fifo.sv
// Generic synchronous FIFO with registered full flag and a combinational head view.
module vsfx_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = full_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue is only taken when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_q || do_pop);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d = (count_d == FULL_CNT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers define which slots are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vsfx_wb.sv
// VSFX writeback: in-order result queue drained into the VRF, plus VSCR[SAT] and CR6 state.
module vsfx_wb
    import vsfx_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vrt_en,
    input  logic [VR_W-1:0]  vrt,
    input  logic             sat,
    input  logic [CR_W-1:0]  cr6,
    input  logic             rc,
    input  logic [VRA_W-1:0] vrt_addr,
    input  logic             wb_ready,
    output logic             wb_valid,
    output logic [VRA_W-1:0] wb_addr,
    output logic [VR_W-1:0]  wb_data,
    input  logic             vscr_wr,
    input  logic             vscr_wdata,
    output logic             vscr_sat,
    output logic [CR_W-1:0]  cr6_q,
    output logic             cr6_upd,
    output logic             full,
    output logic             ovf
);

    wb_entry_t       in_ent, head;
    logic            empty, retire, drop;
    logic            ovf_q, ovf_d;
    logic            vscr_sat_q, vscr_sat_d;
    logic [CR_W-1:0] cr6_field_q, cr6_field_d;
    logic            cr6_upd_q, cr6_upd_d;

    assign in_ent = '{addr: vrt_addr, data: vrt, sat: sat, cr6: cr6, rc: rc};

    vsfx_wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (vrt_en),
        .pop_i   (retire),
        .data_i  (in_ent),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign wb_valid = !empty;
    assign retire   = wb_valid && wb_ready;
    assign drop     = vrt_en && full && !retire;
    assign wb_addr  = wb_valid ? head.addr : '0;
    assign wb_data  = wb_valid ? head.data : '0;

    always_comb begin
        ovf_d       = ovf_q | drop;
        // mtvscr overrides any saturation retiring in the same cycle.
        vscr_sat_d  = vscr_wr ? vscr_wdata : (vscr_sat_q | (retire & head.sat));
        cr6_upd_d   = retire & head.rc;
        cr6_field_d = cr6_upd_d ? head.cr6 : cr6_field_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q       <= 1'b0;
            vscr_sat_q  <= 1'b0;
            cr6_field_q <= '0;
            cr6_upd_q   <= 1'b0;
        end else begin
            ovf_q       <= ovf_d;
            vscr_sat_q  <= vscr_sat_d;
            cr6_field_q <= cr6_field_d;
            cr6_upd_q   <= cr6_upd_d;
        end
    end

    assign ovf      = ovf_q;
    assign vscr_sat = vscr_sat_q;
    assign cr6_q    = cr6_field_q;
    assign cr6_upd  = cr6_upd_q;

endmodule

// File: tb/tb_vsfx_wb.sv
// Randomised + directed bench for vsfx_wb against a queue-based reference model.
module tb_vsfx_wb;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]   addr;
        logic [127:0] data;
        logic         sat;
        logic [3:0]   cr6;
        logic         rc;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         vrt_en;
    logic [127:0] vrt;
    logic         sat;
    logic [3:0]   cr6;
    logic         rc;
    logic [4:0]   vrt_addr;
    logic         wb_ready;
    logic         wb_valid;
    logic [4:0]   wb_addr;
    logic [127:0] wb_data;
    logic         vscr_wr;
    logic         vscr_wdata;
    logic         vscr_sat;
    logic [3:0]   cr6_q;
    logic         cr6_upd;
    logic         full;
    logic         ovf;

    vsfx_wb #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .vrt_en     (vrt_en),
        .vrt        (vrt),
        .sat        (sat),
        .cr6        (cr6),
        .rc         (rc),
        .vrt_addr   (vrt_addr),
        .wb_ready   (wb_ready),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .vscr_wr    (vscr_wr),
        .vscr_wdata (vscr_wdata),
        .vscr_sat   (vscr_sat),
        .cr6_q      (cr6_q),
        .cr6_upd    (cr6_upd),
        .full       (full),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state and an unbounded queue capped by DEPTH.
    ent_t       m_q[$];
    logic       m_ovf, m_sat, m_upd;
    logic [3:0] m_cr6;
    bit         chk_en;
    int         n_vec, n_err;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        ent_t h;
        logic v;
        v = (m_q.size() != 0);
        if (v) h = m_q[0];
        check("wb_valid", 128'(wb_valid), 128'(v));
        check("wb_addr",  128'(wb_addr),  v ? 128'(h.addr) : 128'(0));
        check("wb_data",  wb_data,        v ? h.data : 128'(0));
        check("vscr_sat", 128'(vscr_sat), 128'(m_sat));
        check("cr6_q",    128'(cr6_q),    128'(m_cr6));
        check("cr6_upd",  128'(cr6_upd),  128'(m_upd));
        check("full",     128'(full),     128'(m_q.size() == DEPTH));
        check("ovf",      128'(ovf),      128'(m_ovf));
    endtask

    task automatic model_step();
        ent_t h, n;
        bit   pop;
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_sat = 0; m_upd = 0; m_cr6 = '0;
            return;
        end
        pop = (m_q.size() != 0) && wb_ready;
        if (pop) h = m_q.pop_front();
        if (vrt_en) begin
            if (m_q.size() < DEPTH) begin
                n.addr = vrt_addr; n.data = vrt; n.sat = sat; n.cr6 = cr6; n.rc = rc;
                m_q.push_back(n);
            end else begin
                m_ovf = 1;
            end
        end
        m_sat = vscr_wr ? vscr_wdata : (m_sat | (pop & h.sat));
        m_upd = pop & h.rc;
        if (m_upd) m_cr6 = h.cr6;
    endtask

    // One clock: apply inputs, compare current outputs, advance the model, then the DUT.
    task automatic cycle(input bit r, input bit en, input logic [4:0] a, input logic [127:0] d,
                         input bit s, input logic [3:0] c, input bit rcb, input bit rdy,
                         input bit vw, input bit vd);
        rst = r; vrt_en = en; vrt_addr = a; vrt = d; sat = s; cr6 = c; rc = rcb;
        wb_ready = rdy; vscr_wr = vw; vscr_wdata = vd;
        if (chk_en) check_outputs();
        model_step();
        @(posedge clk);
        #1;
        chk_en = 1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push(input logic [4:0] a, input bit rdy);
        cycle(0, 1, a, rnd128(), $urandom_range(0, 1), 4'($urandom), $urandom_range(0, 1), rdy, 0, 0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, 0, rdy, 0, 0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; chk_en = 0;
        m_ovf = 0; m_sat = 0; m_upd = 0; m_cr6 = '0;

        // Reset held two cycles while results arrive: nothing may be enqueued.
        cycle(1, 1, 5'd9, rnd128(), 1, 4'hf, 1, 0, 0, 0);
        cycle(1, 1, 5'd9, rnd128(), 1, 4'hf, 1, 0, 0, 0);
        idle(1, 0);

        // Single result straight through.
        cycle(0, 1, 5'd7, 128'h0123456789abcdef_fedcba9876543210, 1, 4'b1000, 1, 1, 0, 0);
        idle(3, 1);

        // Back-pressure: five results into a four-deep queue, then drain.
        for (int i = 1; i <= 5; i++) push(5'(i), 0);
        idle(1, 0);
        idle(6, 1);

        // Full queue with enqueue and retire every cycle: no drop.
        cycle(1, 0, '0, '0, 0, '0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) push(5'(10 + i), 0);
        for (int i = 0; i < 8; i++) push(5'(20 + i), 1);
        idle(6, 1);

        // mtvscr clear wins over a saturating retire; later rc=0 retire leaves CR6.
        cycle(0, 1, 5'd3, rnd128(), 1, 4'b0110, 1, 0, 0, 0);
        cycle(0, 0, '0, '0, 0, '0, 0, 1, 1, 0);
        cycle(0, 1, 5'd4, rnd128(), 0, 4'b1111, 0, 1, 0, 0);
        idle(3, 1);

        // Reset mid-drain flushes the queue; a new result then appears alone.
        for (int i = 0; i < 3; i++) push(5'(i + 1), 0);
        cycle(1, 0, '0, '0, 0, '0, 0, 0, 0, 0);
        cycle(0, 1, 5'd30, rnd128(), 1, 4'b0011, 1, 0, 0, 0);
        idle(2, 0);
        idle(3, 1);

        // Random traffic with varying back-pressure, mtvscr writes and rare resets.
        for (int i = 0; i < 1500; i++) begin
            int phase;
            bit rdy;
            phase = (i / 100) % 3;
            rdy = (phase == 0) ? ($urandom_range(0, 9) < 8) :
                  (phase == 1) ? ($urandom_range(0, 9) < 3) : $urandom_range(0, 1);
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 5'($urandom),
                  rnd128(), $urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 1),
                  rdy, $urandom_range(0, 15) == 0, $urandom_range(0, 1));
        end
        idle(2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
